// File: rtl/buckboost_pid_core.sv
// Tick-driven PID controller for a buck-boost stage. Each tick it requests a
// measurement, waits for the ADC ready edge, then computes and clamps the new duty.
module buckboost_pid_core #(
    parameter int DW       = 16,
    parameter int OW       = 8,
    parameter int GW       = 16,
    parameter int SHIFT    = 8,
    parameter int PERIOD   = 270,
    parameter int TIMEOUT  = 1024,
    parameter int DUTY_MIN = 0,
    parameter int DUTY_MAX = (1 << OW) - 1,
    parameter int INT_LIM  = (1 << (DW + 4)) - 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          invert,
    input  logic          ready,
    input  logic [DW-1:0] setpoint,
    input  logic [DW-1:0] voltage_actual,
    input  logic [GW-1:0] kp,
    input  logic [GW-1:0] ki,
    input  logic [GW-1:0] kd,
    output logic          start,
    output logic [OW-1:0] new_duty,
    output logic          duty_valid,
    output logic          timeout_err,
    output logic          busy
);
    localparam int ACC = GW + DW + 8;
    localparam int IW  = DW + 6;
    localparam int CW  = $clog2(PERIOD + 1);
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam logic signed [ACC-1:0] DMIN_S = ACC'(DUTY_MIN);
    localparam logic signed [ACC-1:0] DMAX_S = ACC'(DUTY_MAX);
    localparam logic signed [IW-1:0]  ILIM_S = IW'(INT_LIM);
    localparam logic [OW-1:0]         DMIN_O = OW'(DUTY_MIN);

    typedef enum logic [2:0] {IDLE, REQ, WAIT_READY, CALC, UPDATE} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [TW-1:0]          wait_q, wait_d;
    logic                   ready_prev_q;
    logic                   start_q, start_d, valid_q, valid_d;
    logic                   terr_q, terr_d, busy_q, busy_d;
    logic [OW-1:0]          duty_q, duty_d;
    logic [GW-1:0]          kp_q, kp_d, ki_q, ki_d, kd_q, kd_d;
    logic signed [DW:0]     e_q, e_d, eprev_q, eprev_d, e_cap;
    logic signed [IW-1:0]   integ_q, integ_d, inext_q, inext_d, isum, iclamp;
    logic signed [ACC-1:0]  p_q, p_d, dterm_q, dterm_d, sum, u;
    logic signed [DW+1:0]   ediff;
    logic                   tick, rise, u_hi, u_lo, toward;

    always_comb begin
        e_cap = invert ? $signed({1'b0, voltage_actual} - {1'b0, setpoint})
                       : $signed({1'b0, setpoint} - {1'b0, voltage_actual});
        isum  = integ_q + IW'(e_q);
        if (isum > ILIM_S)       iclamp = ILIM_S;
        else if (isum < -ILIM_S) iclamp = -ILIM_S;
        else                     iclamp = isum;
        ediff = (DW+2)'(e_q) - (DW+2)'(eprev_q);
        sum   = p_q + ACC'($signed({1'b0, ki_q})) * ACC'(inext_q) + dterm_q;
        u     = sum >>> SHIFT;
        u_hi  = u > DMAX_S;
        u_lo  = u < DMIN_S;
        // ki >= 0, so the direction of u's change follows the direction of i_next - integ
        toward = (ki_q != '0) && ((u_hi && (inext_q < integ_q)) || (u_lo && (inext_q > integ_q)));
        rise  = ready && !ready_prev_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        start_d = 1'b0;
        valid_d = 1'b0;
        terr_d  = terr_q;
        duty_d  = duty_q;
        kp_d    = kp_q;
        ki_d    = ki_q;
        kd_d    = kd_q;
        e_d     = e_q;
        eprev_d = eprev_q;
        integ_d = integ_q;
        inext_d = inext_q;
        p_d     = p_q;
        dterm_d = dterm_q;
        tick    = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            wait_d  = '0;
            terr_d  = 1'b0;
            duty_d  = DMIN_O;
            eprev_d = '0;
            integ_d = '0;
        end else begin
            if (cnt_q == CW'(PERIOD - 1)) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            case (state_q)
                IDLE: if (tick) begin
                    state_d = REQ;
                    start_d = 1'b1;
                end
                REQ: begin
                    state_d = WAIT_READY;
                    wait_d  = '0;
                end
                WAIT_READY: begin
                    if (rise) begin
                        state_d = CALC;
                        e_d     = e_cap;
                        kp_d    = kp;
                        ki_d    = ki;
                        kd_d    = kd;
                    end else if (wait_q == TW'(TIMEOUT - 1)) begin
                        state_d = IDLE;
                        terr_d  = 1'b1;
                    end else begin
                        wait_d = wait_q + TW'(1);
                    end
                end
                CALC: begin
                    state_d = UPDATE;
                    p_d     = ACC'($signed({1'b0, kp_q})) * ACC'(e_q);
                    dterm_d = ACC'($signed({1'b0, kd_q})) * ACC'(ediff);
                    inext_d = iclamp;
                end
                UPDATE: begin
                    state_d = IDLE;
                    valid_d = 1'b1;
                    eprev_d = e_q;
                    if (u_hi)      duty_d = DMAX_S[OW-1:0];
                    else if (u_lo) duty_d = DMIN_S[OW-1:0];
                    else           duty_d = u[OW-1:0];
                    if (!(u_hi || u_lo) || toward) integ_d = inext_q;
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            wait_q       <= '0;
            ready_prev_q <= 1'b0;
            start_q      <= 1'b0;
            valid_q      <= 1'b0;
            terr_q       <= 1'b0;
            busy_q       <= 1'b0;
            duty_q       <= DMIN_O;
            kp_q         <= '0;
            ki_q         <= '0;
            kd_q         <= '0;
            e_q          <= '0;
            eprev_q      <= '0;
            integ_q      <= '0;
            inext_q      <= '0;
            p_q          <= '0;
            dterm_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wait_q       <= wait_d;
            ready_prev_q <= ready;
            start_q      <= start_d;
            valid_q      <= valid_d;
            terr_q       <= terr_d;
            busy_q       <= busy_d;
            duty_q       <= duty_d;
            kp_q         <= kp_d;
            ki_q         <= ki_d;
            kd_q         <= kd_d;
            e_q          <= e_d;
            eprev_q      <= eprev_d;
            integ_q      <= integ_d;
            inext_q      <= inext_d;
            p_q          <= p_d;
            dterm_q      <= dterm_d;
        end
    end

    assign start       = start_q;
    assign new_duty    = duty_q;
    assign duty_valid  = valid_q;
    assign timeout_err = terr_q;
    assign busy        = busy_q;

endmodule
